// File: rtl/serial_tx_pkg.sv
// ============================================================================
// Module : serial_tx_pkg
// Brief  : Shared state encoding and line constants for the serial transmitter.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package serial_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

`default_nettype wire

// File: rtl/serial_baud_tick.sv
// ============================================================================
// Module : serial_baud_tick
// Brief  : Bit-period counter with synchronous clear; ticks at terminal count.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module serial_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int                 c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_TERM  = c_CNT_W'(CLKS_PER_BIT - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == c_TERM);

endmodule

`default_nettype wire

// File: rtl/serial_tx_18ec068.sv
// ============================================================================
// Module : serial_tx_18ec068
// Brief  : UART-style LSB-first transmitter with valid/ready input.
//          Define SERIAL_TX_PARITY_EN to insert a parity bit after the data.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module serial_tx_18ec068
    import serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int                 c_IDX_W     = $clog2(DATA_W + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_DATA = c_IDX_W'(DATA_W - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_STOP = c_IDX_W'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2 || DATA_W < 5 || DATA_W > 9 || STOP_BITS < 1 ||
        STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("serial_tx_18ec068: illegal parameter combination");
    end

    tx_state_t          r_state;
    logic [DATA_W-1:0]  r_shreg;
    logic [c_IDX_W-1:0] r_bit_idx;
    logic               w_tick;
    logic               w_clr;
`ifdef SERIAL_TX_PARITY_EN
    logic               r_parity;
`endif

    // Baud counter is held at zero while idle so every frame starts phase-aligned.
    assign w_clr = (r_state == ST_IDLE);

    serial_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_bit_idx <= '0;
            tx        <= TX_IDLE_LEVEL;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
            in_ready  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    tx <= TX_IDLE_LEVEL;
                    if (in_valid && in_ready) begin
                        r_shreg  <= in_data;
`ifdef SERIAL_TX_PARITY_EN
                        r_parity <= (^in_data) ^ (PARITY_ODD != 0);
`endif
                        r_state  <= ST_START;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ST_START: begin
                    tx <= 1'b0;
                    if (w_tick) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // tx follows the state by one cycle, so it samples bit 0 before the shift lands.
                    tx <= r_shreg[0];
                    if (w_tick) begin
                        r_shreg <= r_shreg >> 1;
                        if (r_bit_idx == c_LAST_DATA) begin
                            r_bit_idx <= '0;
`ifdef SERIAL_TX_PARITY_EN
                            r_state   <= ST_PARITY;
`else
                            r_state   <= ST_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                ST_PARITY: begin
                    tx <= r_parity;
                    if (w_tick) begin
                        r_state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    tx <= 1'b1;
                    if (w_tick) begin
                        if (r_bit_idx == c_LAST_STOP) begin
                            r_bit_idx <= '0;
                            r_state   <= ST_IDLE;
                            tx_done   <= 1'b1;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    tx       <= TX_IDLE_LEVEL;
                    busy     <= 1'b0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_tx_18ec068.sv
// ============================================================================
// Module : tb_serial_tx_18ec068
// Brief  : Self-checking bench: two transmitters (1 and 2 stop bits) against a
//          frame-timeline model, plus literal frame captures.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_serial_tx_18ec068;

    localparam int c_CPB = 4;
    localparam int c_DW  = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int c_PAR = 1;
    localparam logic [11:0] c_A5_0 = {1'b1, 1'b0, 8'hA5, 1'b0};
    localparam logic [11:0] c_A5_1 = {2'b11, 1'b1, 8'hA5, 1'b0};
    localparam logic [11:0] c_07_0 = {1'b1, 1'b1, 8'h07, 1'b0};
    localparam logic [11:0] c_07_1 = {2'b11, 1'b0, 8'h07, 1'b0};
    localparam logic [11:0] c_FF_0 = {1'b1, 1'b0, 8'hFF, 1'b0};
`else
    localparam int c_PAR = 0;
    localparam logic [11:0] c_A5_0 = {1'b1, 8'hA5, 1'b0};
    localparam logic [11:0] c_A5_1 = {2'b11, 8'hA5, 1'b0};
    localparam logic [11:0] c_07_0 = {1'b1, 8'h07, 1'b0};
    localparam logic [11:0] c_07_1 = {2'b11, 8'h07, 1'b0};
    localparam logic [11:0] c_FF_0 = {1'b1, 8'hFF, 1'b0};
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic [1:0] w_tx, w_busy, w_rdy, w_done;

    int n_total;
    int n_pass;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        serial_tx_18ec068 #(
            .CLKS_PER_BIT (c_CPB),
            .DATA_W       (c_DW),
            .STOP_BITS    (gi + 1),
            .PARITY_ODD   (gi)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_data  (in_data),
            .in_valid (in_valid),
            .in_ready (w_rdy[gi]),
            .tx       (w_tx[gi]),
            .busy     (w_busy[gi]),
            .tx_done  (w_done[gi])
        );
    end

    function automatic int frame_len(input int i);
        return (1 + c_DW + c_PAR + (i + 1)) * c_CPB;
    endfunction

    // Bit list of one frame: start, data LSB first, optional parity, stop bits.
    function automatic logic [11:0] build_frame(input int i, input logic [7:0] d);
        logic [11:0] f;
        f = '0;
        for (int b = 0; b < c_DW; b++) f[1+b] = d[b];
        if (c_PAR != 0) f[1+c_DW] = (^d) ^ (i != 0);
        for (int s = 0; s < i + 1; s++) f[1+c_DW+c_PAR+s] = 1'b1;
        return f;
    endfunction

    // Model: k = cycles since the accepting edge (-1 when idle).
    int          m_k [2];
    logic [11:0] m_frame [2];
    logic [1:0]  e_tx, e_busy, e_rdy, e_done;

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_k[i]    = -1;
                e_tx[i]   = 1'b1;
                e_busy[i] = 1'b0;
                e_rdy[i]  = 1'b0;
                e_done[i] = 1'b0;
            end else begin
                if (in_valid && e_rdy[i]) begin
                    m_k[i]     = 0;
                    m_frame[i] = build_frame(i, in_data);
                end else if (m_k[i] >= 0 && m_k[i] <= frame_len(i)) begin
                    m_k[i] = m_k[i] + 1;
                end else begin
                    m_k[i] = -1;
                end
                e_busy[i] = (m_k[i] >= 0) && (m_k[i] < frame_len(i));
                e_rdy[i]  = !e_busy[i];
                e_done[i] = (m_k[i] == frame_len(i));
                e_tx[i]   = (m_k[i] >= 1 && m_k[i] <= frame_len(i)) ?
                            m_frame[i][(m_k[i]-1)/c_CPB] : 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic send(input logic [7:0] d);
        int t;
        t        = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (w_rdy[0] !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("send_ready", 32'(w_rdy[0]), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic capture(input int i, output logic [11:0] bits, output int len);
        int t;
        t    = 0;
        bits = '0;
        len  = 0;
        while (w_tx[i] !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        for (int c = 1; c <= 200; c++) begin
            if ((c - 1) % c_CPB == 0 && (c - 1) / c_CPB < 12) bits[(c-1)/c_CPB] = w_tx[i];
            if (w_done[i] === 1'b1) begin
                len = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    logic [11:0] b0, b1;
    int          l0, l1, n0, n1, gap, t;

    initial begin
        n_total  = 0;
        n_pass   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        fork
            forever begin
                @(negedge clk);
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("tx[%0d]", i),       32'(w_tx[i]),   32'(e_tx[i]));
                    chk($sformatf("busy[%0d]", i),     32'(w_busy[i]), 32'(e_busy[i]));
                    chk($sformatf("in_ready[%0d]", i), 32'(w_rdy[i]),  32'(e_rdy[i]));
                    chk($sformatf("tx_done[%0d]", i),  32'(w_done[i]), 32'(e_done[i]));
                end
            end
        join_none

        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({w_tx, w_busy, w_rdy, w_done}), 32'({2'b11, 2'b00, 2'b00, 2'b00}));
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(w_rdy), 32'd3);

        fork
            send(8'hA5);
            capture(0, b0, l0);
            capture(1, b1, l1);
        join
        chk("a5_len_sb1", l0, 40 + 4 * c_PAR);
        chk("a5_bits_sb1", b0, c_A5_0);
        chk("a5_len_sb2", l1, 44 + 4 * c_PAR);
        chk("a5_bits_sb2", b1, c_A5_1);

        @(negedge clk);
        fork
            send(8'h07);
            capture(0, b0, l0);
            capture(1, b1, l1);
        join
        chk("07_bits_sb1", b0, c_07_0);
        chk("07_bits_sb2", b1, c_07_1);

        // Request during a frame must be dropped.
        repeat (2) @(negedge clk);
        send(8'h12);
        repeat (10) @(negedge clk);
        in_data  = 8'h3C;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            n0 += int'(w_done[0]);
            n1 += int'(w_done[1]);
        end
        chk("ignored_done_count_sb1", n0, 1);
        chk("ignored_done_count_sb2", n1, 1);

        // Back-to-back with in_valid held high.
        in_data  = 8'h00;
        in_valid = 1'b1;
        t = 0;
        while (w_rdy[0] !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        @(negedge clk);
        in_data = 8'hFF;
        t = 0;
        while (w_done[0] !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        chk("b2b_first_done", 32'(w_done[0]), 32'd1);
        gap = 0;
        while (w_tx[0] !== 1'b0 && gap < 20) begin @(negedge clk); gap++; end
        in_valid = 1'b0;
        chk("b2b_done_to_start", gap, 2);
        capture(0, b0, l0);
        chk("b2b_second_bits", b0, c_FF_0);
        repeat (60) @(negedge clk);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) == 0);
            in_data  = 8'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        in_valid = 1'b0;
        repeat (100) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
